// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M unsigned MUL/MULHU/DIVU/REMU sequencer driving an external add/sub ALU
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_op selects MUL/MULHU/DIVU/REMU
//   req_a, req_b            multiplicand/dividend, multiplier/divisor
//   resp_valid/resp_ready   response handshake; resp_data carries the result
//   alu_srca/alu_srcb       operands presented to the attached ALU
//   alu_op                  ALU operation (ADD or SUB while running, zero otherwise)
//   alu_result              combinational ALU result, sampled on the same edge
module muldiv_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam logic [OPCODE_LENGTH-1:0] ALU_NOP = '0;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0110);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    // acc holds hi (multiply) or rem (divide); shf holds lo or quo.
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   shf_q, shf_d;
    logic [4:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;

    // Step datapath
    logic [DATA_WIDTH-1:0]   mul_sum;
    logic                    mul_carry;
    logic [DATA_WIDTH-1:0]   div_rs;
    logic                    div_take;
    logic [DATA_WIDTH-1:0]   step_acc;
    logic [DATA_WIDTH-1:0]   step_shf;
    logic [DATA_WIDTH-1:0]   step_result;
    logic                    req_div_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            shf_q       <= '0;
            count_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            shf_q       <= shf_d;
            count_q     <= count_d;
            resp_data_q <= resp_data_d;
        end
    end

    // ALU drive: only RUN uses the ALU, everything else presents zeros.
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_op   = ALU_NOP;
        if (state_q == S_RUN) begin
            alu_srcb = b_q;
            if (op_q[1]) begin
                alu_srca = div_rs;
                alu_op   = ALU_SUB;
            end else begin
                alu_srca = acc_q;
                alu_op   = ALU_ADD;
            end
        end
    end

    always_comb begin
        // Multiply: conditional add of b into hi, then shift {carry,hi,lo} right.
        // The unsigned wrap test recovers the carry the 32-bit ALU drops.
        mul_sum   = shf_q[0] ? alu_result : acc_q;
        mul_carry = shf_q[0] & (alu_result < acc_q);

        // Restoring divide: the bit shifted out of rem[31] makes the 33-bit
        // partial remainder necessarily >= b, so it forces a subtract.
        div_rs   = {acc_q[DATA_WIDTH-2:0], shf_q[DATA_WIDTH-1]};
        div_take = acc_q[DATA_WIDTH-1] | (div_rs >= b_q);

        if (op_q[1]) begin
            step_acc = div_take ? alu_result : div_rs;
            step_shf = {shf_q[DATA_WIDTH-2:0], div_take};
        end else begin
            step_acc = {mul_carry, mul_sum[DATA_WIDTH-1:1]};
            step_shf = {mul_sum[0], shf_q[DATA_WIDTH-1:1]};
        end

        // op[0] picks the acc side (MULHU/REMU) over the shf side (MUL/DIVU).
        step_result = op_q[0] ? step_acc : step_shf;

        req_div_zero = req_op[1] && (req_b == '0);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        b_d         = b_q;
        acc_d       = acc_q;
        shf_d       = shf_q;
        count_d     = count_q;
        resp_data_d = resp_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    b_d     = req_b;
                    count_d = 5'd31;
                    acc_d   = '0;
                    shf_d   = req_a;
                    if (req_div_zero) begin
                        resp_data_d = req_op[0] ? req_a : '1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                shf_d = step_shf;
                if (count_q == 5'd0) begin
                    resp_data_d = step_result;
                    state_d     = S_DONE;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Attached ALU: ADD and SUB only.
    always_comb begin
        case (alu_op)
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0110: alu_result = alu_srca - alu_srcb;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            OP_DIVU:  return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy from accept until response handshake,
    // m_cnt = cycle index after the accept edge.
    bit          m_busy;
    int          m_cnt;
    int          m_lat;
    bit          m_dz;
    logic [1:0]  m_op;
    logic [31:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_op   <= req_op;
                m_dz   <= req_op[1] && (req_b == 32'h0);
                m_lat  <= (req_op[1] && (req_b == 32'h0)) ? 1 : 33;
                m_exp  <= ref_fn(req_op, req_a, req_b);
            end
        end else if (m_cnt >= m_lat && resp_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic       exp_valid;
            logic [3:0] exp_op;
            exp_valid = m_busy && (m_cnt >= m_lat);
            exp_op    = (m_busy && !m_dz && m_cnt <= 32) ? (m_op[1] ? 4'b0110 : 4'b0010) : 4'b0000;
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
            if (exp_valid) chk("resp_data", resp_data, m_exp);
            chk("alu_op", 32'(alu_op), 32'(exp_op));
            if (exp_op == 4'b0000) begin
                chk("alu_srca_idle", alu_srca, 32'h0);
                chk("alu_srcb_idle", alu_srcb, 32'h0);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no req_ready expected accept at %0t", $time);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble inputs after acceptance; they must be ignored.
        req_op = 2'($urandom);
        req_a  = $urandom;
        req_b  = $urandom;
    endtask

    task automatic recv(input int hold, output logic [31:0] d);
        bit ok;
        ok = 1'b0;
        d  = 32'h0;
        for (int i = 0; i < 60; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: got no resp_valid expected response at %0t", $time);
        end else begin
            repeat (hold) @(negedge clk);
            d = resp_data;
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] lit);
        logic [31:0] d;
        chk({name, "_model"}, ref_fn(op, a, b), lit);
        send(op, a, b);
        recv(0, d);
        chk(name, d, lit);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'h0;
        req_b      = 32'h0;
        resp_ready = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'd42);
        directed("mulhu_7x6", OP_MULHU, 32'd7, 32'd6, 32'd0);
        directed("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        directed("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        directed("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        directed("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        directed("divu_top", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001);
        directed("remu_top", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
        directed("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        directed("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5);

        // Backpressure with a pending request during DONE.
        send(OP_MUL, 32'd7, 32'd6);
        for (int i = 0; i < 60 && !resp_valid; i++) @(negedge clk);
        held      = resp_data;
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd100;
        req_b     = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_resp_data", resp_data, 32'd42);
            chk("bp_stable", resp_data, held);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_ready_after_hs", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_accepted", 32'(req_ready), 32'h0);
        recv(0, d);
        chk("bp_divu", d, 32'd14);

        // Asynchronous reset in the middle of RUN.
        send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_resp_data", resp_data, 32'h0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'h0);
        chk("mid_rst_alu_srca", alu_srca, 32'h0);
        chk("mid_rst_alu_srcb", alu_srcb, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("mul_3x5_after_rst", OP_MUL, 32'd3, 32'd5, 32'd15);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = $urandom_range(0, 255);
            send(rop, ra, rb);
            recv($urandom_range(0, 3), d);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
